// File: rtl/arb_out_fifo_pkg.sv
// Shared constants for the arbiter output FIFO.
// Used by the core and by the software register map.
package arb_out_fifo_pkg;

    localparam int DATA_W = 32;
    localparam int LOST_W = 8;

    localparam int DEF_DEPTH          = 1024;
    localparam int DEF_NEAR_FULL_THR  = 768;
    localparam int DEF_NEAR_FULL_HYST = 64;

    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    function automatic logic [LOST_W-1:0] sat_inc(
        input logic [LOST_W-1:0] v
    );
        return (v == LOST_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_out_fifo_ram.sv
// Simple dual-port RAM, synchronous write, registered read.
// No reset so that it maps onto block RAM.
module arb_out_fifo_ram
    import arb_out_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/arb_out_fifo.sv
// FWFT buffer between the readout arbiter and the transport.
// Pipeline: RAM -> RAM read register (s1) -> output register.
module arb_out_fifo
    import arb_out_fifo_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int NEAR_FULL_THR  = DEF_NEAR_FULL_THR,
    parameter int NEAR_FULL_HYST = DEF_NEAR_FULL_HYST,
    localparam int AW            = $clog2(DEPTH),
    localparam int CW            = AW + 1
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              ARB_WRITE_IN,
    input  logic [DATA_W-1:0] ARB_DATA_IN,
    output logic              ARB_READY_OUT,
    input  logic              OUT_READ,
    output logic              OUT_EMPTY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              FIFO_FULL,
    output logic              FIFO_NEAR_FULL,
    output logic [CW-1:0]     FIFO_SIZE,
    input  logic              LOST_CLR,
    output logic [LOST_W-1:0] LOST_CNT
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] THR_C  = CW'(NEAR_FULL_THR);
    localparam logic [CW-1:0] LOW_C  = CW'(NEAR_FULL_THR - NEAR_FULL_HYST);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [CW-1:0]     mem_cnt;
    logic              full_q;
    logic              near_q;
    logic              near_nxt;
    logic              s1_valid;
    logic              out_valid;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] ram_q;
    logic [LOST_W-1:0] lost_q;
    logic              wr_acc;
    logic              drop;
    logic              pop;
    logic              out_load;
    logic              rd_en;

    assign wr_acc   = ARB_WRITE_IN & ~full_q;
    assign drop     = ARB_WRITE_IN & full_q;
    assign pop      = OUT_READ & out_valid;
    assign out_load = s1_valid & (~out_valid | pop);

    // Words still sitting in RAM, not yet read into s1 or the output.
    assign mem_cnt = count - CW'(s1_valid) - CW'(out_valid);
    assign rd_en   = (mem_cnt != '0) & (~s1_valid | out_load);

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop)
            count_nxt = count + 1'b1;
        else if (!wr_acc && pop)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        near_nxt = near_q;
        if (count_nxt >= THR_C)
            near_nxt = 1'b1;
        else if (count_nxt < LOW_C)
            near_nxt = 1'b0;
    end

    arb_out_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (BUS_CLK),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (ARB_DATA_IN),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            near_q     <= 1'b0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data_q <= '0;
            lost_q     <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            full_q    <= (count_nxt == FULL_C);
            near_q    <= near_nxt;
            s1_valid  <= rd_en | (s1_valid & ~out_load);
            out_valid <= out_load | (out_valid & ~pop);
            if (out_load)
                out_data_q <= ram_q;
            if (LOST_CLR)
                lost_q <= '0;
            else if (drop)
                lost_q <= sat_inc(lost_q);
        end
    end

    assign ARB_READY_OUT  = ~full_q;
    assign FIFO_FULL      = full_q;
    assign FIFO_NEAR_FULL = near_q;
    assign FIFO_SIZE      = count;
    assign OUT_EMPTY      = ~out_valid;
    assign OUT_DATA       = out_data_q;
    assign LOST_CNT       = lost_q;

endmodule

// File: tb/tb_arb_out_fifo.sv
// Self-checking bench for arb_out_fifo (DEPTH=16, THR=12, HYST=4).
// Reference model: a word queue stamped with its write edge number.
module tb_arb_out_fifo;

    localparam int DEPTH = 16;
    localparam int THR   = 12;
    localparam int HYST  = 4;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST = 1'b1;
    logic        ARB_WRITE_IN = 1'b0;
    logic [31:0] ARB_DATA_IN = '0;
    logic        ARB_READY_OUT;
    logic        OUT_READ = 1'b0;
    logic        OUT_EMPTY;
    logic [31:0] OUT_DATA;
    logic        FIFO_FULL;
    logic        FIFO_NEAR_FULL;
    logic [4:0]  FIFO_SIZE;
    logic        LOST_CLR = 1'b0;
    logic [7:0]  LOST_CNT;

    arb_out_fifo #(
        .DEPTH          (DEPTH),
        .NEAR_FULL_THR  (THR),
        .NEAR_FULL_HYST (HYST)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .ARB_WRITE_IN   (ARB_WRITE_IN),
        .ARB_DATA_IN    (ARB_DATA_IN),
        .ARB_READY_OUT  (ARB_READY_OUT),
        .OUT_READ       (OUT_READ),
        .OUT_EMPTY      (OUT_EMPTY),
        .OUT_DATA       (OUT_DATA),
        .FIFO_FULL      (FIFO_FULL),
        .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
        .FIFO_SIZE      (FIFO_SIZE),
        .LOST_CLR       (LOST_CLR),
        .LOST_CNT       (LOST_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        int unsigned wc;
    } ent_t;

    ent_t        mq[$];
    int unsigned cyc = 0;
    int          mlost = 0;
    bit          mnear = 0;

    // A word written on edge k is presentable from edge k+2 onwards.
    function automatic bit m_vis();
        return (mq.size() > 0) && (mq[0].wc + 2 <= cyc);
    endfunction

    task automatic model_edge(input logic wr, input logic [31:0] d,
                              input logic rd, input logic clr);
        bit vis;
        bit full;
        vis  = m_vis();
        full = (mq.size() == DEPTH);
        cyc++;
        if (rd && vis)
            void'(mq.pop_front());
        if (wr && !full)
            mq.push_back('{d, cyc});
        if (clr)
            mlost = 0;
        else if (wr && full && mlost < 255)
            mlost++;
        if (mq.size() >= THR)
            mnear = 1;
        else if (mq.size() < THR - HYST)
            mnear = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        mlost = 0;
        mnear = 0;
    endtask

    task automatic check_model();
        bit vis;
        vis = m_vis();
        chk("size",  32'(FIFO_SIZE),      32'(mq.size()));
        chk("full",  32'(FIFO_FULL),      32'(mq.size() == DEPTH));
        chk("ready", 32'(ARB_READY_OUT),  32'(mq.size() != DEPTH));
        chk("near",  32'(FIFO_NEAR_FULL), 32'(mnear));
        chk("lost",  32'(LOST_CNT),       32'(mlost));
        chk("empty", 32'(OUT_EMPTY),      32'(!vis));
        if (vis)
            chk("data", OUT_DATA, mq[0].d);
    endtask

    task automatic step(input logic wr, input logic [31:0] d,
                        input logic rd, input logic clr);
        ARB_WRITE_IN = wr;
        ARB_DATA_IN  = d;
        OUT_READ     = rd;
        LOST_CLR     = clr;
        @(posedge BUS_CLK);
        model_edge(wr, d, rd, clr);
        #1;
        check_model();
    endtask

    // Asserted and released between clock edges; checked with no clock edge.
    task automatic do_reset();
        BUS_RST = 1'b1;
        #1;
        chk("rst_empty", 32'(OUT_EMPTY),      32'd1);
        chk("rst_full",  32'(FIFO_FULL),      32'd0);
        chk("rst_near",  32'(FIFO_NEAR_FULL), 32'd0);
        chk("rst_ready", 32'(ARB_READY_OUT),  32'd1);
        chk("rst_lost",  32'(LOST_CNT),       32'd0);
        chk("rst_data",  OUT_DATA,            32'd0);
        chk("rst_size",  32'(FIFO_SIZE),      32'd0);
        ARB_WRITE_IN = 1'b0;
        OUT_READ     = 1'b0;
        LOST_CLR     = 1'b0;
        #1;
        BUS_RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rd;
        logic [4:0]  size;
        logic        empty;
        logic [31:0] data;
    } vec_t;

    vec_t tv[6];

    initial begin
        int got;
        int pw;
        int pr;
        logic [4:0]  hs_size[5];
        logic        hs_near[5];

        tv[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 5'd1, 1'b1, 32'h0};
        tv[1] = '{1'b0, 32'h0,        1'b0, 5'd1, 1'b1, 32'h0};
        tv[2] = '{1'b0, 32'h0,        1'b0, 5'd1, 1'b0, 32'hDEADBEEF};
        tv[3] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 32'hDEADBEEF};
        tv[4] = '{1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 32'hDEADBEEF};
        tv[5] = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b1, 32'hDEADBEEF};

        do_reset();

        // single word through the FWFT path
        for (int i = 0; i < 6; i++) begin
            step(tv[i].wr, tv[i].d, tv[i].rd, 1'b0);
            chk("tv_size",  32'(FIFO_SIZE), 32'(tv[i].size));
            chk("tv_empty", 32'(OUT_EMPTY), 32'(tv[i].empty));
            if (!tv[i].empty)
                chk("tv_data", OUT_DATA, tv[i].data);
        end

        // fill, overflow, drain
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(FIFO_FULL),     32'd1);
        chk("fill_ready", 32'(ARB_READY_OUT), 32'd0);
        chk("fill_size",  32'(FIFO_SIZE),     32'd16);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hBAD0 + 32'(i), 1'b0, 1'b0);
        chk("ovf_lost", 32'(LOST_CNT),  32'd3);
        chk("ovf_size", 32'(FIFO_SIZE), 32'd16);
        got = 0;
        for (int n = 0; n < 40 && got < 16; n++) begin
            if (!OUT_EMPTY) begin
                chk("drain_data", OUT_DATA, 32'(got));
                got++;
            end
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_cnt",   32'(got),       32'd16);
        chk("drain_empty", 32'(OUT_EMPTY), 32'd1);

        // hysteresis
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 10)
                chk("hy_11", 32'(FIFO_NEAR_FULL), 32'd0);
        end
        chk("hy_12", 32'(FIFO_NEAR_FULL), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        hs_size = '{5'd11, 5'd10, 5'd9, 5'd8, 5'd7};
        hs_near = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("hy_size", 32'(FIFO_SIZE),      32'(hs_size[i]));
            chk("hy_near", 32'(FIFO_NEAR_FULL), 32'(hs_near[i]));
        end

        // streaming at count 5
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
            chk("st_size",   32'(FIFO_SIZE), 32'd5);
            chk("st_bubble", 32'(OUT_EMPTY), 32'd0);
        end
        chk("st_head", OUT_DATA, 32'h2000 + 32'd995);

        // corner cases at full
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD, 1'b1, 1'b0);
        chk("wr_rd_full_lost", 32'(LOST_CNT),  32'd1);
        chk("wr_rd_full_size", 32'(FIFO_SIZE), 32'd15);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        chk("refill_full", 32'(FIFO_FULL), 32'd1);
        step(1'b1, 32'hBAD, 1'b0, 1'b1);
        chk("clr_drop", 32'(LOST_CNT), 32'd0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 32'hBAD, 1'b0, 1'b0);
        chk("lost_sat", 32'(LOST_CNT), 32'd255);
        for (int i = 0; i < 7; i++)
            step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_size", 32'(FIFO_SIZE), 32'd9);

        // asynchronous reset mid-burst at count 9
        ARB_WRITE_IN = 1'b1;
        ARB_DATA_IN  = 32'h5555;
        do_reset();
        step(1'b1, 32'h1234, 1'b0, 1'b0);
        chk("post_rst_size", 32'(FIFO_SIZE), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_empty", 32'(OUT_EMPTY), 32'd0);
        chk("post_rst_data",  OUT_DATA,       32'h1234);

        // randomized traffic with varying write/read pressure
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
            pr = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
            for (int i = 0; i < 400; i++)
                step(1'($urandom_range(0, 99) < pw), $urandom,
                     1'($urandom_range(0, 99) < pr),
                     1'($urandom_range(0, 99) < 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/arb_out_fifo.md
# arb_out_fifo

Buffer between the readout arbiter output of the chip core (ARB_WRITE_OUT / ARB_DATA_OUT / ARB_READY_OUT) and the transport interface (USB/SiTCP readout). Absorbs arbiter bursts in a 32-bit first-word-fall-through FIFO and supplies the FIFO_FULL / FIFO_NEAR_FULL flags the core uses for trigger veto. It also counts protocol violations (writes while not ready) so that no data is lost silently.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, >= 4.
- NEAR_FULL_THR, 768: word count at which FIFO_NEAR_FULL asserts; 1..DEPTH-1.
- NEAR_FULL_HYST, 64: FIFO_NEAR_FULL deasserts when count < NEAR_FULL_THR - NEAR_FULL_HYST; < NEAR_FULL_THR.

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  reset, asynchronous, active-high.
- ARB_WRITE_IN  in  1  write strobe from the arbiter.
- ARB_DATA_IN  in  32  write data.
- ARB_READY_OUT  out  1  space available; equals ~FIFO_FULL.
- OUT_READ  in  1  pop strobe from the transport.
- OUT_EMPTY  out  1  no valid word on OUT_DATA.
- OUT_DATA  out  32  head word, valid while OUT_EMPTY=0.
- FIFO_FULL  out  1  count == DEPTH.
- FIFO_NEAR_FULL  out  1  hysteretic threshold flag.
- FIFO_SIZE  out  $clog2(DEPTH)+1  words held, including the output register.
- LOST_CLR  in  1  synchronous clear of LOST_CNT.
- LOST_CNT  out  8  saturating count of dropped writes.

## Operation
- Write accepted when ARB_WRITE_IN=1 and FIFO_FULL=0 at the clock edge. This holds even if OUT_READ pops in the same cycle.
- ARB_WRITE_IN=1 while FIFO_FULL=1: the word is dropped, LOST_CNT increments and saturates at 255, and memory and pointers are unchanged.
- LOST_CLR=1 clears LOST_CNT. If a drop occurs in the same cycle, LOST_CLR wins and LOST_CNT reads 0.
- Pop when OUT_READ=1 and OUT_EMPTY=0. OUT_READ while empty is ignored and has no side effect.
- FWFT output stage: RAM (registered read) → output register. Prefetch from the RAM whenever the output register is empty or being popped, and the RAM holds data.
- FIFO_SIZE: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle. The range 0..DEPTH must never be exceeded.
- FIFO_FULL and FIFO_NEAR_FULL are registered and derived from the next-state count.
  - FIFO_NEAR_FULL sets when next count >= NEAR_FULL_THR.
  - FIFO_NEAR_FULL clears when next count < NEAR_FULL_THR - NEAR_FULL_HYST.
  - Otherwise FIFO_NEAR_FULL holds its value.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty is decided by the count, not by pointer equality.
- Reset (asynchronous, any time including mid-burst):
  - pointers = 0, count = 0.
  - OUT_EMPTY=1, FIFO_FULL=0, FIFO_NEAR_FULL=0, ARB_READY_OUT=1.
  - LOST_CNT=0, OUT_DATA=0.
  - RAM contents are don't-care.

## Timing
- Write latency: a word written into an empty FIFO on edge k has OUT_EMPTY=0 with valid OUT_DATA after edge k+2.
- Throughput: one write and one pop per cycle sustained. Back-to-back pops with data in the RAM present the next word after every edge with no bubbles.
- Flag latency: FIFO_FULL, ARB_READY_OUT, FIFO_NEAR_FULL and FIFO_SIZE reflect the operations of edge k immediately after edge k.
- With the FIFO at DEPTH-1 words, a write on edge k drives ARB_READY_OUT=0 after edge k. A second write on edge k+1 is dropped.
- Reset release: writes are accepted from the first edge with BUS_RST=0.

## Structure
- Shared package: data width constant (32), LOST_CNT width (8), and the default DEPTH and threshold values, for reuse by the core and the software register map.
- One sub-module, arb_out_fifo_ram: simple dual-port RAM with DEPTH x 32 bits, synchronous write, registered read, and no reset, so it infers block RAM.
- Top level holds the pointers, count, flags, FWFT output register and LOST_CNT.

## Test plan
- Single word: write 0xDEADBEEF on edge 0 → OUT_EMPTY=0 and OUT_DATA=0xDEADBEEF after edge 2. Pop it → OUT_EMPTY=1, FIFO_SIZE=0.
- Fill and overflow (DEPTH=16, THR=12, HYST=4): 16 writes → FIFO_FULL=1, ARB_READY_OUT=0. Three more writes → LOST_CNT=3 and contents unchanged. Drain → words 0..15 come out in order.
- Hysteresis (same parameters): FIFO_NEAR_FULL rises at count 12. It stays high at count 9 and 8, and falls at count 7.
- Streaming: simultaneous write and read every cycle for 1000 cycles starting at count 5 → FIFO_SIZE stays 5, order is preserved, no bubbles, and pointers wrap correctly.
- Corner cases: at full, write+read on the same edge → write dropped and LOST_CNT+1. LOST_CLR in the same cycle as a drop → LOST_CNT=0. LOST_CNT saturates at 255 after 300 drops.
- Async reset mid-burst at count 9 → all outputs take reset values immediately, with no clock needed. The next written word appears first at the output.
